// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle-latency imem, and buffers returned words in a prefetch FIFO.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [63:0] PC_STEP    = 64'd4
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] imem_raddr,
   output logic        imem_rd_en,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [63:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        fetch_fault,
   output logic [63:0] fault_pc
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   state_t          state;
   logic [63:0]     fetchPc;
   logic [PW-1:0]   rdPtr, wrPtr;
   logic [CW-1:0]   count;
   logic            epoch;
   logic            vld_p1;
   logic [63:0]     pc_p1;
   logic            epoch_p1;
   logic [31:0]     instrMem [FIFO_DEPTH];
   logic [63:0]     pcMem    [FIFO_DEPTH];
   logic            pop, push, issue, faultNow;
   logic [CW:0]     occupancy;
   logic [63:0]     loadPc;

   function automatic logic [63:0] alignPc(input logic [63:0] pc);
      return pc & ~64'h3;
   endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = (redirect_pc[1:0] != 2'b00);
   assign faultNow   = fetch_fault;
   assign loadPc     = redirect_pc;
`else
   assign faultNow   = 1'b0;
   assign loadPc     = alignPc(redirect_pc);
`endif

   assign instr_valid = (count != '0);
   assign pop         = instr_valid & instr_ready;
   // Slots already claimed (buffered + in flight) after this cycle's pop must leave room for a new request.
   assign occupancy   = (CW+1)'(count) + (CW+1)'(vld_p1) - (CW+1)'(pop);
   assign issue       = !reset && (state == RUN) && !redirect && (occupancy < (CW+1)'(FIFO_DEPTH));
   assign push        = vld_p1 && (epoch_p1 == epoch) && !redirect;
   assign imem_rd_en  = issue;
   assign imem_raddr  = fetchPc[31:0];
   assign instr       = instr_valid ? instrMem[rdPtr] : '0;
   assign instr_pc    = instr_valid ? pcMem[rdPtr]    : '0;

   // p0 -> p1: control state, request tracking and FIFO bookkeeping
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= BOOT;
         fetchPc  <= RESET_PC;
         count    <= '0;
         rdPtr    <= '0;
         wrPtr    <= '0;
         epoch    <= 1'b0;
         epoch_p1 <= 1'b0;
         vld_p1   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_fault <= 1'b0;
         fault_pc    <= '0;
`endif
      end else if (redirect) begin
         state   <= FLUSH;
         fetchPc <= loadPc;
         count   <= '0;
         rdPtr   <= '0;
         wrPtr   <= '0;
         epoch   <= ~epoch;
         vld_p1  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_fault <= misaligned;
         if (misaligned) fault_pc <= redirect_pc;
`endif
      end else begin
         case (state)
            BOOT:    state <= RUN;
            RUN:     state <= RUN;
            FLUSH:   if (!faultNow) state <= RUN;
            default: state <= BOOT;
         endcase
         vld_p1 <= issue;
         if (issue) begin
            fetchPc  <= fetchPc + PC_STEP;
            epoch_p1 <= epoch;
         end
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // p1 -> FIFO: request PC and returned word, no reset on data
   always_ff @(posedge clock) begin
      if (issue) pc_p1 <= fetchPc;
      if (push) begin
         instrMem[wrPtr] <= imem_rdata;
         pcMem[wrPtr]    <= pc_p1;
      end
   end

endmodule
